// File: rtl/inert_pkg.sv
// inert_pkg: shared state encoding, init command words and read base address for the inertial sequencer
package inert_pkg;
  typedef enum logic [2:0] {PWR_WAIT, INIT, INIT_WAIT, WAIT_INT, READ, READ_WAIT} state_t;
  localparam logic [6:0] RD_BASE = 7'h22;
  localparam int N_RD = 10;
  localparam logic [15:0] INIT_CMD0 = 16'h0D02;
  localparam logic [15:0] INIT_CMD1 = 16'h1062;
  localparam logic [15:0] INIT_CMD2 = 16'h1162;
  localparam logic [15:0] INIT_CMD3 = 16'h1460;
  function automatic logic [15:0] init_cmd(input logic [1:0] i);
    return i == 2'd0 ? INIT_CMD0 : i == 2'd1 ? INIT_CMD1 : i == 2'd2 ? INIT_CMD2 : INIT_CMD3;
  endfunction
endpackage

// File: rtl/inert_rd_seq_if.sv
// inert_rd_seq_if: SPI command/response handshake between the sequencer and its SPI master
interface inert_rd_seq_if;
  logic wrt, done;
  logic [15:0] cmd, rd_data;
  modport master (output wrt, cmd, input done, rd_data);
  modport slave (input wrt, cmd, output done, rd_data);
endinterface

// File: rtl/int_sync.sv
// int_sync: two-flop synchronizer for the asynchronous sensor data-ready line
module int_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
endmodule

// File: rtl/inert_rd_seq.sv
// inert_rd_seq: powers up and configures the inertial sensor over SPI, then reads ten bytes per data-ready
module inert_rd_seq
  import inert_pkg::*;
#(
  parameter int FAST_SIM = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic INT,
  inert_rd_seq_if.master spi,
  output logic init_done,
  output logic vld,
  output logic [15:0] ptch_rt,
  output logic [15:0] roll_rt,
  output logic [15:0] yaw_rt,
  output logic [15:0] ax,
  output logic [15:0] ay
);
  state_t state, state_d;
  logic [15:0] timer, timer_d, cmd, cmd_d;
  logic [3:0] idx, idx_d;
  logic wrt, wrt_d, vld_d, init_d, int_s, pwr_full, cap, last;
  logic [7:0] bytes [N_RD];
  int_sync u_sync (.clk(clk), .rst(rst), .d(INT), .q(int_s));
  assign spi.wrt = wrt;
  assign spi.cmd = cmd;
  assign pwr_full = FAST_SIM != 0 ? timer[9] : &timer;
  assign cap = state == READ_WAIT && spi.done;
  assign last = idx == 4'(N_RD - 1);
  always_comb begin
    state_d = state;
    timer_d = timer;
    idx_d = idx;
    cmd_d = cmd;
    wrt_d = 1'b0;
    vld_d = 1'b0;
    init_d = init_done;
    case (state)
      PWR_WAIT: begin
        cmd_d = '0;
        timer_d = pwr_full ? timer : timer + 16'd1;
        state_d = pwr_full ? INIT : PWR_WAIT;
      end
      INIT: begin
        wrt_d = 1'b1;
        cmd_d = init_cmd(idx[1:0]);
        state_d = INIT_WAIT;
      end
      INIT_WAIT: if (spi.done) begin
        init_d = idx == 4'd3;
        idx_d = idx == 4'd3 ? 4'd0 : idx + 4'd1;
        cmd_d = idx == 4'd3 ? 16'h0000 : cmd;
        state_d = idx == 4'd3 ? WAIT_INT : INIT;
      end
      WAIT_INT: begin
        cmd_d = '0;
        idx_d = '0;
        state_d = int_s ? READ : WAIT_INT;
      end
      READ: begin
        wrt_d = 1'b1;
        cmd_d = {1'b1, RD_BASE + 7'(idx), 8'h00};
        state_d = READ_WAIT;
      end
      READ_WAIT: if (spi.done) begin
        vld_d = last;
        idx_d = last ? 4'd0 : idx + 4'd1;
        cmd_d = last ? 16'h0000 : cmd;
        state_d = last ? WAIT_INT : READ;
      end
      default: state_d = PWR_WAIT;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= PWR_WAIT;
      timer <= '0;
      idx <= '0;
      cmd <= '0;
      wrt <= 1'b0;
      vld <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state <= state_d;
      timer <= timer_d;
      idx <= idx_d;
      cmd <= cmd_d;
      wrt <= wrt_d;
      vld <= vld_d;
      init_done <= init_d;
    end
  // the last byte comes straight from rd_data so all five words land together with vld
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {ptch_rt, roll_rt, yaw_rt, ax, ay} <= '0;
      for (int i = 0; i < N_RD; i++) bytes[i] <= '0;
    end else begin
      if (cap) bytes[idx] <= spi.rd_data[7:0];
      if (cap && last) begin
        ptch_rt <= {bytes[1], bytes[0]};
        roll_rt <= {bytes[3], bytes[2]};
        yaw_rt <= {bytes[5], bytes[4]};
        ax <= {bytes[7], bytes[6]};
        ay <= {spi.rd_data[7:0], bytes[8]};
      end
    end
endmodule

// File: tb/tb_inert_rd_seq.sv
// tb_inert_rd_seq: directed checks of power-up, init writes, sample reads, signed data, INT handling and reset
module tb_inert_rd_seq;
  logic clk = 1'b0, rst = 1'b1, INT = 1'b0;
  logic init_done, vld;
  logic [15:0] ptch_rt, roll_rt, yaw_rt, ax, ay;
  inert_rd_seq_if bus ();
  inert_rd_seq #(.FAST_SIM(1)) dut (
    .clk(clk), .rst(rst), .INT(INT), .spi(bus), .init_done(init_done), .vld(vld),
    .ptch_rt(ptch_rt), .roll_rt(roll_rt), .yaw_rt(yaw_rt), .ax(ax), .ay(ay)
  );
  always #5 clk = ~clk;
  int cyc = 0, wrt_cnt = 0, vld_cnt = 0, last_wrt = 0, last_done = 0, vld_cyc = 0, gap_err = 0;
  int n_chk = 0, n_fail = 0, spur_req = 0, spur_seen = 0, ri = 0;
  logic [15:0] rc;
  logic [15:0] cmd_log [$];
  logic [7:0] rd_bytes [10];
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (bus.wrt) begin
      cmd_log.push_back(bus.cmd);
      if (wrt_cnt > 0 && cyc - last_wrt < 3) gap_err++;
      wrt_cnt++;
      last_wrt = cyc;
    end
    if (bus.done) last_done = cyc;
    if (vld) begin
      vld_cnt++;
      vld_cyc = cyc;
    end
  end
  // SPI master model: done three cycles after wrt, plus on-demand spurious done pulses
  initial begin
    bus.done = 1'b0;
    bus.rd_data = '0;
    forever begin
      @(posedge clk); #1;
      if (spur_req != spur_seen) begin
        spur_seen = spur_req;
        bus.done = 1'b1;
        @(posedge clk); #1;
        bus.done = 1'b0;
      end else if (bus.wrt) begin
        rc = bus.cmd;
        ri = int'(rc[14:8]) - 'h22;
        repeat (2) @(posedge clk);
        #1;
        bus.rd_data = {8'hA5, (rc[15] && ri >= 0 && ri < 10) ? rd_bytes[ri] : 8'h00};
        bus.done = 1'b1;
        @(posedge clk); #1;
        bus.done = 1'b0;
      end
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic power_up(input string tag);
    int n, w0, t0, lb;
    w0 = wrt_cnt;
    lb = cmd_log.size();
    @(negedge clk);
    rst = 1'b0;
    t0 = cyc;
    n = 0;
    while (wrt_cnt == w0 && n < 2000) begin @(posedge clk); n++; end
    @(posedge clk);
    check($sformatf("%s first wrt delay %0d", tag, last_wrt - t0), 32'(last_wrt - t0 >= 512 && last_wrt - t0 <= 516), 1);
    n = 0;
    while (!init_done && n < 300) begin @(posedge clk); n++; end
    #1;
    check({tag, " init_done"}, 32'(init_done), 1);
    check({tag, " init wrt count"}, 32'(cmd_log.size() - lb >= 4), 1);
    check({tag, " init cmd0"}, 32'(cmd_log[lb]), 32'h0D02);
    check({tag, " init cmd1"}, 32'(cmd_log[lb + 1]), 32'h1062);
    check({tag, " init cmd2"}, 32'(cmd_log[lb + 2]), 32'h1162);
    check({tag, " init cmd3"}, 32'(cmd_log[lb + 3]), 32'h1460);
  endtask
  task automatic run_seq(input string tag);
    int n, v0, w0, lb;
    v0 = vld_cnt;
    w0 = wrt_cnt;
    lb = cmd_log.size();
    INT = 1'b1;
    n = 0;
    while (wrt_cnt == w0 && n < 50) begin @(posedge clk); n++; end
    INT = 1'b0;
    n = 0;
    while (vld_cnt == v0 && n < 200) begin @(posedge clk); n++; end
    check({tag, " vld seen"}, 32'(vld_cnt - v0), 1);
    check({tag, " done->vld latency"}, 32'(vld_cyc - last_done), 1);
    for (int i = 0; i < 10; i++)
      check($sformatf("%s read cmd %0d", tag, i), 32'(cmd_log[lb + i]), 32'hA200 + 32'(i) * 32'h100);
  endtask
  initial begin
    int v0, w0, n;
    for (int i = 0; i < 10; i++) rd_bytes[i] = 8'(i + 1);
    repeat (3) @(posedge clk);
    #1;
    check("rst wrt", 32'(bus.wrt), 0);
    check("rst vld", 32'(vld), 0);
    check("rst init_done", 32'(init_done), 0);
    check("rst cmd", 32'(bus.cmd), 0);
    check("rst samples", 32'(ptch_rt | roll_rt | yaw_rt | ax | ay), 0);
    power_up("pwr1");
    check("idle cmd", 32'(bus.cmd), 0);
    run_seq("seq1");
    #1;
    check("seq1 ptch", 32'(ptch_rt), 32'h0201);
    check("seq1 roll", 32'(roll_rt), 32'h0403);
    check("seq1 yaw", 32'(yaw_rt), 32'h0605);
    check("seq1 ax", 32'(ax), 32'h0807);
    check("seq1 ay", 32'(ay), 32'h0A09);
    repeat (20) @(posedge clk);
    #1;
    check("hold ptch", 32'(ptch_rt), 32'h0201);
    check("hold ay", 32'(ay), 32'h0A09);
    check("hold cmd idle", 32'(bus.cmd), 0);
    rd_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h80, 8'hFF, 8'h00, 8'h80, 8'h7F, 8'h01};
    w0 = wrt_cnt;
    v0 = vld_cnt;
    spur_req++;
    repeat (6) @(posedge clk);
    check("spurious done no wrt", 32'(wrt_cnt - w0), 0);
    INT = 1'b1;
    n = 0;
    while (wrt_cnt == w0 && n < 50) begin @(posedge clk); n++; end
    INT = 1'b0;
    repeat (8) @(posedge clk);
    INT = 1'b1;
    repeat (5) @(posedge clk);
    INT = 1'b0;
    n = 0;
    while (vld_cnt == v0 && n < 200) begin @(posedge clk); n++; end
    repeat (15) @(posedge clk);
    #1;
    check("toggle vld count", 32'(vld_cnt - v0), 1);
    check("toggle wrt count", 32'(wrt_cnt - w0), 10);
    check("signed ptch", 32'(ptch_rt), 32'h2211);
    check("signed roll", 32'(roll_rt), 32'h4433);
    check("signed yaw", 32'(yaw_rt), 32'hFF80);
    check("signed ax", 32'(ax), 32'h8000);
    check("signed ay", 32'(ay), 32'h017F);
    for (int i = 0; i < 10; i++)
      check($sformatf("toggle read cmd %0d", i), 32'(cmd_log[cmd_log.size() - 10 + i]), 32'hA200 + 32'(i) * 32'h100);
    w0 = wrt_cnt;
    v0 = vld_cnt;
    INT = 1'b1;
    n = 0;
    while (vld_cnt < v0 + 3 && n < 600) begin @(posedge clk); n++; end
    INT = 1'b0;
    repeat (80) @(posedge clk);
    check("b2b vld count", 32'(vld_cnt - v0 >= 3), 1);
    check("b2b wrt per vld", 32'(wrt_cnt - w0), 32'(10 * (vld_cnt - v0)));
    check("wrt spacing", 32'(gap_err), 0);
    for (int i = 0; i < 10; i++) rd_bytes[i] = 8'(i + 1);
    run_seq("seq2");
    INT = 1'b1;
    n = 0;
    while (bus.cmd != 16'hA700 && n < 200) begin @(posedge clk); n++; end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst cmd", 32'(bus.cmd), 0);
    check("midrst wrt", 32'(bus.wrt), 0);
    check("midrst vld", 32'(vld), 0);
    check("midrst init_done", 32'(init_done), 0);
    check("midrst samples", 32'(ptch_rt | roll_rt | yaw_rt | ax | ay), 0);
    repeat (3) @(posedge clk);
    power_up("pwr2");
    INT = 1'b0;
    repeat (80) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/inert_rd_seq.md
INERT_RD_SEQ -- requirements
Module: inert_rd_seq

Interface
REQ-001 SHALL have parameter FAST_SIM, default 1, which selects the short power-up wait when nonzero.
REQ-002 SHALL have port clk, input, 1, the single system clock; all flops are on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset; it is asynchronous and active-high.
REQ-004 SHALL have port INT, input, 1, the sensor data-ready line; it is asynchronous to clk.
REQ-005 SHALL have port wrt, output, 1, a one-cycle pulse that launches an SPI transaction.
REQ-006 SHALL have port cmd, output, 16, the SPI command word; it is held stable from the wrt pulse until done.
REQ-007 SHALL have port done, input, 1, a one-cycle pulse from the SPI master when a transaction completes.
REQ-008 SHALL have port rd_data, input, 16, the SPI response; bits [7:0] carry the register byte.
REQ-009 SHALL have port init_done, output, 1, held high once sensor configuration has completed.
REQ-010 SHALL have port vld, output, 1, a one-cycle pulse when a new sample set is valid.
REQ-011 SHALL have ports ptch_rt, roll_rt, yaw_rt, ax, ay, output, 16 each, signed raw readings.

Function
REQ-012 SHALL synchronize INT with two flops before any use; only the synchronized value is referenced.
REQ-013 SHALL implement the states PWR_WAIT, INIT, INIT_WAIT, WAIT_INT, READ and READ_WAIT.
REQ-014 SHALL, in PWR_WAIT, count a 16-bit timer until it is full (all ones); when FAST_SIM is set, it SHALL instead stop at bit 9 set (512 cycles). It SHALL then enter INIT.
REQ-015 SHALL issue four writes in order: 16'h0D02, 16'h1062, 16'h1162, 16'h1460.
- Each write is a wrt pulse followed by INIT_WAIT until done.
- After done on the 4th write, init_done is set and the state is WAIT_INT.
REQ-016 SHALL, in WAIT_INT, leave when synchronized INT is high and enter READ with index 0.
REQ-017 SHALL, in READ, issue cmd = {1'b1, addr[6:0], 8'h00}, where addr = 7'h22 + index (index 0..9), and pulse wrt.
REQ-018 SHALL, on done in READ_WAIT, capture rd_data[7:0] into the byte buffer slot for the current index.
- Byte order: pitch L/H 0x22/23, roll 0x24/25, yaw 0x26/27, ax 0x28/29, ay 0x2A/2B.
REQ-019 SHALL, after capturing index 9, update all five outputs simultaneously as {H,L} on the clock after the done of index 9, pulse vld in that same cycle, and return to WAIT_INT.
REQ-020 SHALL hold the sample outputs constant between vld pulses.
REQ-021 SHALL have a latency from the done of index 9 to vld of exactly 1 clock.
REQ-022 SHALL ignore INT while a read sequence is in progress; INT still high after vld starts a new sequence immediately (level-sensitive).
REQ-023 SHALL ignore done outside INIT_WAIT and READ_WAIT.
REQ-024 SHALL never assert wrt while a transaction is outstanding; between successive wrt pulses there are at least 2 cycles.
REQ-025 SHALL keep cmd at 16'h0000 when idle in PWR_WAIT and WAIT_INT.
REQ-026 SHALL treat all readings as two's complement; no scaling or sign manipulation is performed.

Reset
REQ-027 SHALL, on rst high at any time, including mid-transaction, immediately force the following values:
- state PWR_WAIT; timer and index 0;
- wrt, vld, init_done 0; cmd 16'h0000;
- all sample outputs and the byte buffer 16'h0000 / 8'h00;
- synchronizer flops 0.
REQ-028 SHALL, after rst deasserts, repeat the full power-up wait and configuration.

Structure
REQ-029 SHALL take the state enum, the four init command constants, and the base address 7'h22 from shared package inert_pkg.
REQ-030 SHALL instantiate exactly one sub-module: int_sync, a 2-flop synchronizer with async active-high reset.
REQ-031 SHALL drive cmd and the outputs from registers only; there are no combinational paths from done or rd_data to outputs.

Verification
REQ-032 Power-up (FAST_SIM=1), done returned 3 cycles after each wrt -> first wrt occurs after 512 cycles; cmd sequence is 0D02, 1062, 1162, 1460; init_done rises after the 4th done.
REQ-033 INT high with rd_data[7:0] = 0x01..0x0A for indices 0..9 -> cmd 0xA200..0xAB00 in order; vld 1 cycle after the last done; ptch_rt=0x0201, roll_rt=0x0403, yaw_rt=0x0605, ax=0x0807, ay=0x0A09.
REQ-034 Bytes giving yaw = 0xFF80 and ax = 0x8000 -> outputs are exactly 0xFF80 and 0x8000 (signed -128 and -32768).
REQ-035 INT toggled mid-sequence plus a spurious done in WAIT_INT -> exactly one vld; no extra wrt; the sequence is unaltered.
REQ-036 INT held high continuously -> back-to-back sequences; exactly one vld per 10 reads.
REQ-037 rst asserted during index 5 READ_WAIT -> all outputs are 0 in the same cycle; on release the 512-cycle wait and the 4 init writes repeat before any read.
